// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator driven by a pixel-enable tick.
// Ports:
//   clk         board clock
//   rst         asynchronous reset, active-low
//   tick        pixel enable, one clk wide per pixel period
//   hsync/vsync sync outputs, active level SYNC_POL
//   video_on    high while the current coordinate is in the visible area
//   pixel_x/y   current pixel coordinate
//   line_start  1-clk pulse when pixel_x wraps to 0
//   frame_start 1-clk pulse when (pixel_x,pixel_y) wraps to (0,0)
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // First coordinate of each segment and the last legal coordinate.
  localparam logic [CNT_W-1:0] H_B_FRONT = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] H_B_SYNC  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] H_B_BACK  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_B_FRONT = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] V_B_SYNC  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] V_B_BACK  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } seg_e;

  seg_e             h_state_q, h_state_d;
  seg_e             v_state_q, v_state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             line_wrap;

  // Segment FSM step: advances when the new coordinate reaches the next
  // segment boundary; a zero coordinate always lands in ACTIVE so that an
  // upset counter resynchronises the state at the wrap.
  function automatic seg_e seg_next(input seg_e cur, input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] b_front,
                                    input logic [CNT_W-1:0] b_sync,
                                    input logic [CNT_W-1:0] b_back);
    seg_e nxt;
    nxt = cur;
    if (c == '0) begin
      nxt = ST_ACTIVE;
    end else begin
      case (cur)
        ST_ACTIVE: if (c == b_front) nxt = ST_FRONT;
        ST_FRONT:  if (c == b_sync)  nxt = ST_SYNC;
        ST_SYNC:   if (c == b_back)  nxt = ST_BACK;
        ST_BACK:   nxt = ST_BACK;
        default:   nxt = ST_ACTIVE;
      endcase
    end
    return nxt;
  endfunction

  // Next-state and output decode.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    line_wrap     = (x_q >= H_LAST);

    if (tick) begin
      // ">=" folds any out-of-range value back to 0 on this tick.
      if (line_wrap) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q >= V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
        if (y_q > V_LAST) y_d = '0;
      end

      h_state_d  = seg_next(h_state_q, x_d, H_B_FRONT, H_B_SYNC, H_B_BACK);
      v_state_d  = seg_next(v_state_q, y_d, V_B_FRONT, V_B_SYNC, V_B_BACK);
      hsync_d    = (h_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d    = (v_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_d = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= '0;
      y_q           <= '0;
      h_state_q     <= ST_ACTIVE;
      v_state_q     <= ST_ACTIVE;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: a full-size instance plus a shrunken-timing
// instance (so whole frames fit in a short run), both checked every clk
// against a tick-count reference model through per-instance scoreboards.
module tb_vga_sync_gen;

  localparam int unsigned BW = 10;
  localparam int unsigned SW = 6;

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          hs;
    bit          vs;
    bit          vid;
    bit          ls;
    bit          fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tick;

  logic          b_hs, b_vs, b_vid, b_ls, b_fs;
  logic [BW-1:0] b_x, b_y;
  logic          s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [SW-1:0] s_x, s_y;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exp_t        qb[$];
  exp_t        qs[$];
  int unsigned n_cnt = 0;
  bit          ticked = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen dut_big (
    .clk(clk), .rst(rst), .tick(tick),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
    .pixel_x(b_x), .pixel_y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b1), .CNT_W(SW)
  ) dut_small (
    .clk(clk), .rst(rst), .tick(tick),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  // Reference: after n ticks since reset the raster position is simply
  // n mod H_TOTAL / (n div H_TOTAL) mod V_TOTAL; everything else follows.
  function automatic exp_t ref_out(input int unsigned n, input bit tk,
                                   input int unsigned hd, input int unsigned hf,
                                   input int unsigned hsw, input int unsigned hb,
                                   input int unsigned vd, input int unsigned vf,
                                   input int unsigned vsw, input int unsigned vb,
                                   input bit pol);
    exp_t e;
    int unsigned ht;
    int unsigned vt;
    ht    = hd + hf + hsw + hb;
    vt    = vd + vf + vsw + vb;
    e.x   = n % ht;
    e.y   = (n / ht) % vt;
    e.hs  = (e.x >= hd + hf && e.x < hd + hf + hsw) ? pol : ~pol;
    e.vs  = (e.y >= vd + vf && e.y < vd + vf + vsw) ? pol : ~pol;
    e.vid = (e.x < hd) && (e.y < vd);
    e.ls  = tk && (e.x == 0);
    e.fs  = tk && (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  function automatic exp_t ref_big(input int unsigned n, input bit tk);
    return ref_out(n, tk, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic exp_t ref_small(input int unsigned n, input bit tk);
    return ref_out(n, tk, 16, 2, 4, 3, 10, 2, 2, 3, 1'b1);
  endfunction

  task automatic check_one(input string nm, input exp_t e,
                           input int unsigned x, input int unsigned y,
                           input bit hs, input bit vs, input bit vid,
                           input bit ls, input bit fs);
    checks++;
    if (x != e.x || y != e.y || hs != e.hs || vs != e.vs || vid != e.vid ||
        ls != e.ls || fs != e.fs) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%0b vs=%0b vid=%0b ls=%0b fs=%0b exp x=%0d y=%0d hs=%0b vs=%0b vid=%0b ls=%0b fs=%0b",
               nm, $time, x, y, hs, vs, vid, ls, fs,
               e.x, e.y, e.hs, e.vs, e.vid, e.ls, e.fs);
    end
  endtask

  task automatic check_val(input string nm, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  // Model: on each clk edge, advance the tick count and queue the expected outputs.
  always @(posedge clk) begin
    if (!rst) begin
      n_cnt  = 0;
      ticked = 1'b0;
    end else begin
      ticked = tick;
      if (tick) n_cnt++;
    end
    qb.push_back(ref_big(n_cnt, ticked));
    qs.push_back(ref_small(n_cnt, ticked));
  end

  // Monitor: outputs present a new value every clk; pop and compare just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qb.size() == 0) begin
      checks++; errors++;
      $display("FAIL big_queue_empty t=%0t", $time);
    end else begin
      e = qb.pop_front();
      check_one("big", e, 32'(b_x), 32'(b_y), b_hs, b_vs, b_vid, b_ls, b_fs);
    end
    if (qs.size() == 0) begin
      checks++; errors++;
      $display("FAIL small_queue_empty t=%0t", $time);
    end else begin
      e = qs.pop_front();
      check_one("small", e, 32'(s_x), 32'(s_y), s_hs, s_vs, s_vid, s_ls, s_fs);
    end
  end

  initial begin
    int unsigned fs_t[$];
    int unsigned ls_t[$];
    bit          found;

    rst  = 1'b1;
    tick = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Pixel tick every 4th clk across more than two full-size lines.
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      tick = (i % 4 == 3);
    end

    // Tick tied high: measure line/frame pulse spacing on the small instance.
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (s_fs) fs_t.push_back(i);
      if (s_ls) ls_t.push_back(i);
      tick = 1'b1;
    end
    checks++;
    if (fs_t.size() < 3) begin
      errors++;
      $display("FAIL frame_pulse_count got %0d exp >=3", fs_t.size());
    end
    for (int i = 1; i < fs_t.size(); i++)
      check_val("frame_period", fs_t[i] - fs_t[i-1], 425);
    for (int i = 1; i < ls_t.size(); i++)
      check_val("line_period", ls_t[i] - ls_t[i-1], 25);

    // Random tick pattern.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tick = 1'($urandom_range(0, 1));
    end

    // Seek (8,5), gate tick low for 1000 clk, then resume one pixel.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (s_x == SW'(8) && s_y == SW'(5)) begin
        found = 1'b1;
        tick  = 1'b0;
      end else begin
        tick = 1'b1;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL seek_gate_point timeout");
    end
    repeat (1000) @(negedge clk);
    check_val("frozen_x", 32'(s_x), 8);
    check_val("frozen_y", 32'(s_y), 5);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_val("resume_x", 32'(s_x), 9);
    check_val("resume_y", 32'(s_y), 5);

    // Seek (20,12) and assert reset mid-frame for 3 clk.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (s_x == SW'(20) && s_y == SW'(12)) found = 1'b1;
      else tick = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL seek_reset_point timeout");
    end
    tick = 1'b1;
    rst  = 1'b0;
    #1;
    check_one("async_rst_small", ref_small(0, 1'b0), 32'(s_x), 32'(s_y),
              s_hs, s_vs, s_vid, s_ls, s_fs);
    check_one("async_rst_big", ref_big(0, 1'b0), 32'(b_x), 32'(b_y),
              b_hs, b_vs, b_vid, b_ls, b_fs);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tick = 1'b1;
    end
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
